tau_settle_monitor: RTL

Digital monitor for the emulated regulator model's 7-bit `out` sample stream. It measures the model's step response over model step pulses: the first-order time constant (samples to 63% of the swing) and, optionally, the settling time to a final target. A characterization sequencer starts each measurement after changing VREF/VREG. The monitor hands back counts through a done/ack handshake.

---
 rtl/tau_settle_monitor.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/tau_settle_monitor.sv
// Measures the 63% crossing index and (optionally) the settling index of a sampled step response.
// Settling measurement is compiled in when TAU_MON_SETTLE_EN is defined.
module tau_settle_monitor #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 16'hFFFF,
    parameter int TOL     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       target,
    input  logic [6:0]       out_val,
    input  logic             sample_en,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] t63,
    output logic [CNT_W-1:0] t_settle,
    output logic [2:0]       o_dbg_state
);

    // Handshake: start is sampled only in IDLE; done stays high with stable results
    // until ack is seen on a clock edge in DONE (ack beats a simultaneous start).
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CAPTURE   = 3'd1,
        S_TRACK63   = 3'd2,
        S_TRACK_SET = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ALL1    = '1;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_t63;
    logic [6:0]        r_target;
    logic [6:0]        r_thr;
    logic              r_rising;

    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_tmo_hit;
    logic signed [7:0] w_delta;
    logic signed [15:0] w_prod;
    logic [6:0]        w_thr;
    logic              w_cross;

    assign w_cnt_nxt = r_cnt + CNT_W'(1);
    assign w_tmo_hit = (w_cnt_nxt == TMO_CNT);
    assign w_delta   = $signed({1'b0, r_target}) - $signed({1'b0, out_val});
    // 161/256 ~= 1 - 1/e; the arithmetic shift floors for negative swings.
    assign w_prod    = 16'(w_delta) * 16'sd161;
    assign w_thr     = out_val + 7'(w_prod >>> 8);
    assign w_cross   = r_rising ? (out_val >= r_thr) : (out_val <= r_thr);

`ifdef TAU_MON_SETTLE_EN
    logic [CNT_W-1:0]  r_t_settle;
    logic [7:0]        w_absdiff;
    logic              w_in_band;

    assign w_absdiff = (out_val >= r_target) ? {1'b0, out_val - r_target}
                                             : {1'b0, r_target - out_val};
    assign w_in_band = (w_absdiff <= 8'(TOL));
    assign t_settle  = r_t_settle;
`else
    logic w_tol_unused;
    assign w_tol_unused = (TOL != 0);
    assign t_settle     = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
            r_t63      <= '0;
            r_target   <= '0;
            r_thr      <= '0;
            r_rising   <= 1'b0;
`ifdef TAU_MON_SETTLE_EN
            r_t_settle <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_target   <= target;
                        r_cnt      <= '0;
                        r_timeout  <= 1'b0;
                        r_t63      <= '0;
`ifdef TAU_MON_SETTLE_EN
                        r_t_settle <= '0;
`endif
                        r_busy     <= 1'b1;
                        r_state    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (sample_en) begin
                        r_thr    <= w_thr;
                        r_rising <= ~w_delta[7];
                        if (w_delta == 8'sd0) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_TRACK63;
                        end
                    end
                end
                S_TRACK63: begin
                    if (sample_en) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cross) begin
                            r_t63 <= w_cnt_nxt;
`ifdef TAU_MON_SETTLE_EN
                            if (w_in_band) begin
                                r_t_settle <= w_cnt_nxt;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                                r_state    <= S_DONE;
                            end else if (w_tmo_hit) begin
                                r_t_settle <= ALL1;
                                r_timeout  <= 1'b1;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                                r_state    <= S_DONE;
                            end else begin
                                r_state <= S_TRACK_SET;
                            end
`else
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
`endif
                        end else if (w_tmo_hit) begin
                            r_t63      <= ALL1;
`ifdef TAU_MON_SETTLE_EN
                            r_t_settle <= ALL1;
`endif
                            r_timeout  <= 1'b1;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
`ifdef TAU_MON_SETTLE_EN
                S_TRACK_SET: begin
                    if (sample_en) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_in_band) begin
                            r_t_settle <= w_cnt_nxt;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else if (w_tmo_hit) begin
                            r_t_settle <= ALL1;
                            r_timeout  <= 1'b1;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
`endif
                S_DONE: begin
                    if (ack) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign t63         = r_t63;
    assign o_dbg_state = r_state;

endmodule
